uart_cmd_rx: RTL

Parametrised UART command receiver: oversampled 8N1 serial input, mid-bit sampling with start-bit validation and framing check, then an in-line command decoder driving an N-digit active-low hex 7-segment display plus a byte mirror on LEDs. Sits directly behind the board serial pin and owns the front-panel display; replaces the fixed-rate, two-digit receiver with a rate- and width-configurable one.

---
 rtl/uart_cmd_rx.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_rx.sv
// ============================================================================
// Module   : uart_cmd_rx
// Brief    : Oversampled UART receiver with in-line command decoder driving an
//            N-digit active-low hex 7-segment display and an LED byte mirror.
//            Define UART_RX_PARITY_EN for 8E1 framing (default 8N1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_DIGITS   = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    serial,
  output logic [7:0]              leds,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    byte_valid,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    cmd_err
);

  localparam int              c_CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(CLKS_PER_BIT - 1);
  localparam int              c_DW   = 4 * NUM_DIGITS;

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_STOP   = 3'd3;
  localparam logic [2:0] c_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd5;
`endif

  logic [2:0]          r_state;
  logic [2:0]          w_next;
  logic                r_sync1;
  logic                r_sync2;
  logic                w_rx;
  logic [c_CW-1:0]     r_cnt;
  logic [2:0]          r_bit_cnt;
  logic [7:0]          r_shift;
  logic [c_DW-1:0]     r_data;
  logic [c_DW-1:0]     w_data_shift;
  logic [7*NUM_DIGITS-1:0] w_font;
  logic                w_half;
  logic                w_full;
  logic                w_sample;
  logic                w_stop;
  logic                w_cnt_clr;
  logic                w_accept;
  logic                w_ferr;
  logic                w_par_bad;
`ifdef UART_RX_PARITY_EN
  logic                r_par;
  logic                w_perr;
`endif

  function automatic logic [6:0] f_font(input logic [3:0] n);
    case (n)
      4'h0: f_font = 7'h01;  4'h1: f_font = 7'h4F;
      4'h2: f_font = 7'h12;  4'h3: f_font = 7'h06;
      4'h4: f_font = 7'h4C;  4'h5: f_font = 7'h24;
      4'h6: f_font = 7'h20;  4'h7: f_font = 7'h0F;
      4'h8: f_font = 7'h00;  4'h9: f_font = 7'h04;
      4'hA: f_font = 7'h08;  4'hB: f_font = 7'h60;
      4'hC: f_font = 7'h31;  4'hD: f_font = 7'h42;
      4'hE: f_font = 7'h30;  default: f_font = 7'h38;
    endcase
  endfunction

  // Two-flop synchroniser; resets to idle-high so no false start after reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx   = r_sync2;
  assign w_half = (r_cnt == c_HALF);
  assign w_full = (r_cnt == c_FULL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= c_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (!w_rx) w_next = c_START;
      c_START: if (w_half) w_next = w_rx ? c_IDLE : c_DATA;
`ifdef UART_RX_PARITY_EN
      c_DATA:   if (w_full && r_bit_cnt == 3'd7) w_next = c_PARITY;
      c_PARITY: if (w_full) w_next = c_STOP;
`else
      c_DATA:   if (w_full && r_bit_cnt == 3'd7) w_next = c_STOP;
`endif
      c_STOP:  if (w_full) w_next = w_rx ? c_IDLE : c_BREAK;
      c_BREAK: if (w_rx) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign w_par_bad = ^{r_shift, r_par};
`else
  assign w_par_bad = 1'b0;
`endif

  always_comb begin
    w_sample  = 1'b0;
    w_stop    = 1'b0;
    w_cnt_clr = w_full;
    case (r_state)
      c_IDLE:  w_cnt_clr = 1'b1;
      c_START: w_cnt_clr = w_half;
      c_DATA:  w_sample  = w_full;
      c_STOP:  w_stop    = w_full;
      default: ;
    endcase
    w_accept = w_stop && w_rx && !w_par_bad;
    w_ferr   = w_stop && !w_rx;
`ifdef UART_RX_PARITY_EN
    w_perr   = w_stop && w_rx && w_par_bad;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
      if (r_state == c_IDLE) r_bit_cnt <= 3'd0;
      else if (w_sample)     r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_sample) r_shift <= {w_rx, r_shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_par      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (r_state == c_PARITY && w_full) r_par <= w_rx;
      parity_err <= w_perr;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  generate
    if (NUM_DIGITS > 1) begin : g_shift_multi
      assign w_data_shift = {r_data[c_DW-5:0], r_shift[3:0]};
    end else begin : g_shift_single
      assign w_data_shift = r_shift[3:0];
    end
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_font
      assign w_font[7*k +: 7] = f_font(r_data[4*k +: 4]);
    end
  endgenerate

  // Command executes on the same edge that registers the stop sample
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      leds       <= 8'd0;
      seg        <= '1;
      r_data     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      byte_valid <= w_accept;
      frame_err  <= w_ferr;
      cmd_err    <= 1'b0;
      if (w_accept) begin
        leds <= r_shift;
        case (r_shift[7:4])
          4'h1:    seg     <= '1;
          4'h2:    r_data  <= w_data_shift;
          4'h4:    seg     <= w_font;
          default: cmd_err <= 1'b1;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
